// File: rtl/prog_clk_divider_pkg.sv
// Shared types and constants for the programmable clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle between the divider and its user.
interface prog_clk_divider_if #(
  parameter int WIDTH = 8
);

  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             clkout;
  logic             tick;
  logic [WIDTH-1:0] div_cur;
  logic             busy;
  logic             err;

  modport master (
    output en, div_val, div_load,
    input  clkout, tick, div_cur, busy, err
  );

  modport slave (
    input  en, div_val, div_load,
    output clkout, tick, div_cur, busy, err
  );

endinterface

// File: rtl/prog_clk_divider.sv
// Synchronous integer clock divider (N = 2 .. 2^WIDTH-1), near-50% duty,
// runtime divisor reload at period boundaries and graceful stop.
module prog_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic           clk,
  input  logic           rst,
  prog_clk_divider_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             legal;
  logic [WIDTH:0]   half_d;

  assign wrap  = (state_q != IDLE) && (k_q == div_cur_q - WIDTH'(1));
  assign legal = (bus.div_val >= WIDTH'(MIN_DIV));

  // Shadow divisor: a legal load at a wrap overrides any pending value.
  always_comb begin
    div_cur_d  = div_cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = err_q;
    if (wrap && pend_vld_q) begin
      div_cur_d  = pend_q;
      pend_vld_d = 1'b0;
    end
    if (bus.div_load) begin
      if (!legal) begin
        err_d = 1'b1;
      end else if (state_q == IDLE || wrap) begin
        div_cur_d  = bus.div_val;
        pend_vld_d = 1'b0;
      end else begin
        pend_d     = bus.div_val;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.en) state_d = RUN;
      RUN:      if (wrap) state_d = bus.en ? RUN : IDLE;
                else if (!bus.en) state_d = STOPPING;
      STOPPING: if (wrap) state_d = bus.en ? RUN : IDLE;
                else if (bus.en) state_d = RUN;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    k_d      = (state_q == IDLE || wrap) ? '0 : k_q + WIDTH'(1);
    half_d   = ({1'b0, div_cur_d} + (WIDTH+1)'(1)) >> 1;
    clkout_d = (state_d != IDLE) && ({1'b0, k_d} < half_d);
    tick_d   = (state_d != IDLE) && (k_d == div_cur_d - WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      div_cur_q  <= WIDTH'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      clkout_q   <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      div_cur_q  <= div_cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      clkout_q   <= clkout_d;
      tick_q     <= tick_d;
    end
  end

  assign bus.clkout  = clkout_q;
  assign bus.tick    = tick_q;
  assign bus.div_cur = div_cur_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.err     = err_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed scenarios plus random traffic,
// every cycle compared against a period-level reference model.
module tb_prog_clk_divider;

  localparam int WIDTH = 8;
  localparam int DEF   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  prog_clk_divider_if #(.WIDTH(WIDTH)) bus ();

  prog_clk_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: an output period is "active" or not; phase counts within it.
  int m_active;
  int m_phase;
  int m_n;
  int m_pend;
  int m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_phase  = 0;
    m_n      = DEF;
    m_pend   = -1;
    m_err    = 0;
  endtask

  task automatic model_step(input bit en, input bit dl, input int dv);
    bit end_of_period;
    int next_n;
    end_of_period = (m_active != 0) && (m_phase == m_n - 1);
    next_n = m_n;
    if (end_of_period && m_pend >= 0) begin
      next_n = m_pend;
      m_pend = -1;
    end
    if (dl) begin
      if (dv < 2) m_err = 1;
      else if (m_active == 0 || end_of_period) begin
        next_n = dv;
        m_pend = -1;
      end else m_pend = dv;
    end
    if (m_active == 0) begin
      if (en) begin
        m_active = 1;
        m_phase  = 0;
      end
    end else if (end_of_period) begin
      m_phase = 0;
      if (!en) m_active = 0;
    end else begin
      m_phase++;
    end
    m_n = next_n;
  endtask

  task automatic compare_all();
    int exp_clk, exp_tick;
    exp_clk  = (m_active != 0 && m_phase < (m_n + 1) / 2) ? 1 : 0;
    exp_tick = (m_active != 0 && m_phase == m_n - 1) ? 1 : 0;
    check_eq("clkout",  32'(bus.clkout),  32'(exp_clk));
    check_eq("tick",    32'(bus.tick),    32'(exp_tick));
    check_eq("div_cur", 32'(bus.div_cur), 32'(m_n));
    check_eq("busy",    32'(bus.busy),    32'(m_active));
    check_eq("err",     32'(bus.err),     32'(m_err));
  endtask

  task automatic drive_cycle(input bit en, input bit dl, input logic [7:0] dv);
    bus.en       = en;
    bus.div_load = dl;
    bus.div_val  = dv;
    @(posedge clk);
    model_step(en, dl, int'(dv));
    #1;
    compare_all();
  endtask

  task automatic run(input bit en, input int cycles);
    for (int i = 0; i < cycles; i++) drive_cycle(en, 1'b0, 8'd0);
  endtask

  // Load a divisor from IDLE and bring the phase to k.
  task automatic start_at(input logic [7:0] n, input int k);
    run(1'b0, 300);
    drive_cycle(1'b0, 1'b1, n);
    drive_cycle(1'b1, 1'b0, 8'd0);
    run(1'b1, k);
  endtask

  initial begin
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
    model_reset();
    #12;
    check_eq("rst_clkout",  32'(bus.clkout),  32'd0);
    check_eq("rst_div_cur", 32'(bus.div_cur), 32'(DEF));
    check_eq("rst_busy",    32'(bus.busy),    32'd0);
    rst = 1'b1;
    @(negedge clk);

    run(1'b1, 40);
    run(1'b0, 20);
    drive_cycle(1'b0, 1'b1, 8'd5);
    run(1'b1, 20);
    run(1'b0, 10);
    drive_cycle(1'b0, 1'b1, 8'd2);
    run(1'b1, 10);

    start_at(8'd16, 3);
    drive_cycle(1'b1, 1'b1, 8'd6);
    run(1'b1, 30);
    start_at(8'd16, 15);
    drive_cycle(1'b1, 1'b1, 8'd6);
    run(1'b1, 14);

    start_at(8'd8, 4);
    run(1'b0, 12);
    start_at(8'd8, 4);
    run(1'b0, 2);
    run(1'b1, 20);

    drive_cycle(1'b1, 1'b1, 8'd0);
    run(1'b1, 5);
    drive_cycle(1'b1, 1'b1, 8'd1);
    run(1'b1, 20);

    start_at(8'd7, 3);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_eq("arst_clkout",  32'(bus.clkout),  32'd0);
    check_eq("arst_tick",    32'(bus.tick),    32'd0);
    check_eq("arst_busy",    32'(bus.busy),    32'd0);
    check_eq("arst_err",     32'(bus.err),     32'd0);
    check_eq("arst_div_cur", 32'(bus.div_cur), 32'(DEF));
    @(negedge clk);
    rst = 1'b1;
    run(1'b1, 34);

    for (int i = 0; i < 3000; i++) begin
      bit en, dl;
      logic [7:0] dv;
      en = ($urandom_range(0, 15) != 0);
      if ((i / 200) % 3 == 2) en = ($urandom_range(0, 3) == 0);
      dl = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 19))
        0:       dv = 8'd255;
        1:       dv = 8'd254;
        default: dv = 8'($urandom_range(0, 12));
      endcase
      drive_cycle(en, dl, dv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
